// File: rtl/multi_channel_clk_divider.sv
// Multi-channel programmable clock divider with shadowed per-channel configuration.
// Each channel emits a one-cycle pulse or a ~50% duty output; new settings land only at a period boundary.
module multi_channel_clk_divider #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 15,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] sel_s;
  logic              xfer_s;

  // An out-of-range cfg_ch selects no channel, so it is always accepted and dropped
  assign cfg_ready = ~|(sel_s & pending);
  assign xfer_s    = cfg_valid & cfg_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] sh_div_r;
    logic             mode_r;
    logic             sh_mode_r;
    logic             pending_r;
    logic             clk_out_r;
    logic [WIDTH-1:0] term_s;
    logic [WIDTH-1:0] half_s;
    logic             run_s;
    logic             tick_s;
    logic             apply_s;
    logic             load_s;
    logic             out_nxt_s;

    assign sel_s[c] = (cfg_ch == CH_W'(c));

    // Terminal count, duty threshold ceil(div/2) and the shadow apply/load decisions
    always_comb begin
      term_s    = div_r - WIDTH'(1'b1);
      half_s    = (div_r >> 1'b1) + WIDTH'(div_r[0]);
      run_s     = ch_en[c] && (div_r != {WIDTH{1'b0}});
      tick_s    = rst_n && run_s && (count_r == term_s);
      apply_s   = pending_r && (tick_s || sync || !run_s);
      load_s    = xfer_s && sel_s[c];
      out_nxt_s = run_s && (mode_r ? (count_r < half_s) : (count_r == term_s));
    end

    // Channel state: counter, output register, active and shadow configuration
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_r   <= {WIDTH{1'b0}};
        div_r     <= WIDTH'(DEFAULT_DIV);
        mode_r    <= 1'b0;
        sh_div_r  <= WIDTH'(DEFAULT_DIV);
        sh_mode_r <= 1'b0;
        pending_r <= 1'b0;
        clk_out_r <= 1'b0;
      end else begin
        if (sync || !run_s || tick_s) begin
          count_r <= {WIDTH{1'b0}};
        end else begin
          count_r <= count_r + WIDTH'(1'b1);
        end

        clk_out_r <= out_nxt_s;

        // A load can only happen while pending is clear, so it never collides with an apply
        if (apply_s) begin
          div_r     <= sh_div_r;
          mode_r    <= sh_mode_r;
          pending_r <= 1'b0;
        end else if (load_s) begin
          sh_div_r  <= cfg_div;
          sh_mode_r <= cfg_mode;
          pending_r <= 1'b1;
        end else begin
          pending_r <= pending_r;
        end
      end
    end

    assign clk_out[c] = clk_out_r;
    assign tick[c]    = tick_s;
    assign pending[c] = pending_r;
  end

endmodule

// File: tb/tb_multi_channel_clk_divider.sv
// Directed bench for multi_channel_clk_divider with hand-computed expectations.
module tb_multi_channel_clk_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ch_en;
  logic       sync;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [3:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  multi_channel_clk_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .clk_out   (clk_out),
    .tick      (tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] div, input logic mode,
                           input string tag);
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_mode  = mode;
    cfg_valid = 1'b1;
    #1;
    check(tag, {3'b000, cfg_ready}, 4'b0001);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    ch_en     = 4'b0001;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
    cfg_mode  = 1'b0;

    // Reset state
    step(); step();
    check("rst_clk_out", clk_out, 4'b0000);
    check("rst_tick", tick, 4'b0000);
    check("rst_pending", pending, 4'b0000);
    check("rst_cfg_ready", {3'b000, cfg_ready}, 4'b0001);

    // Defaults: ch0 divides by 15, pulse lags tick by one cycle
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      check("def_tick", tick, {3'b000, (k % 15) == 14});
      check("def_clk_out", clk_out, {3'b000, (k % 15) == 0});
    end

    // ch1 duty mode div=6 -> 111000
    cfg_write(2'd1, 8'd6, 1'b1, "cfg_ch1_div6_ready");
    check("ch1_pending_set", pending, 4'b0010);
    step();
    check("ch1_pending_applied", pending, 4'b0000);
    ch_en = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("duty6", {3'b000, clk_out[1]}, {3'b000, ((k - 1) % 6) < 3});
    end

    // ch1 duty mode div=7 -> 1111000
    ch_en = 4'b0000;
    cfg_write(2'd1, 8'd7, 1'b1, "cfg_ch1_div7_ready");
    step();
    check("ch1_idle_low", {3'b000, clk_out[1]}, 4'b0000);
    ch_en = 4'b0010;
    for (int k = 1; k <= 14; k++) begin
      step();
      check("duty7", {3'b000, clk_out[1]}, {3'b000, ((k - 1) % 7) < 4});
    end

    // Mid-period reconfig of ch0: old 15-cycle period completes, then 4-cycle periods
    ch_en = 4'b0001;
    for (int k = 1; k <= 5; k++) step();
    cfg_write(2'd0, 8'd4, 1'b0, "cfg_ch0_div4_ready");
    check("mid_pending", pending, 4'b0001);
    cfg_ch = 2'd0;
    #1;
    check("mid_ready_ch0", {3'b000, cfg_ready}, 4'b0000);
    cfg_ch = 2'd1;
    #1;
    check("mid_ready_ch1", {3'b000, cfg_ready}, 4'b0001);
    for (int k = 7; k <= 14; k++) begin
      step();
      check("old_tick", {3'b000, tick[0]}, {3'b000, k == 14});
      check("old_pending", {3'b000, pending[0]}, 4'b0001);
    end
    step();
    check("wrap_pending", pending, 4'b0000);
    check("wrap_clk_out", {3'b000, clk_out[0]}, 4'b0001);
    check("wrap_tick", {3'b000, tick[0]}, 4'b0000);
    for (int j = 1; j <= 8; j++) begin
      step();
      check("div4_tick", {3'b000, tick[0]}, {3'b000, (j % 4) == 3});
      check("div4_clk_out", {3'b000, clk_out[0]}, {3'b000, (j % 4) == 0});
    end

    // sync realigns ch0 div=3 and ch2 div=5
    ch_en = 4'b0000;
    cfg_write(2'd0, 8'd3, 1'b0, "cfg_ch0_div3_ready");
    cfg_write(2'd2, 8'd5, 1'b0, "cfg_ch2_div5_ready");
    step();
    check("sync_cfg_applied", pending, 4'b0000);
    ch_en = 4'b0101;
    for (int k = 1; k <= 7; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick0", tick, 4'b0000);
    for (int k = 1; k <= 30; k++) begin
      step();
      check("sync_tick", tick, {1'b0, (k % 5) == 4, 1'b0, (k % 3) == 2});
    end

    // div=0 on ch3 stays silent while ch_en toggles
    ch_en = 4'b0000;
    cfg_write(2'd3, 8'd0, 1'b0, "cfg_ch3_div0_ready");
    step();
    check("div0_applied", pending, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      ch_en = (i % 2 == 1) ? 4'b1000 : 4'b0000;
      step();
      check("div0_tick", tick, 4'b0000);
      check("div0_clk_out", clk_out, 4'b0000);
    end

    // div=1 on ch3: constant high in pulse mode, then in duty mode
    ch_en = 4'b1000;
    cfg_write(2'd3, 8'd1, 1'b0, "cfg_ch3_div1_ready");
    step();
    check("div1_tick", tick, 4'b1000);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("div1_pulse_high", clk_out, 4'b1000);
    end
    cfg_write(2'd3, 8'd1, 1'b1, "cfg_ch3_div1_duty_ready");
    for (int k = 1; k <= 4; k++) begin
      step();
      check("div1_duty_high", clk_out, 4'b1000);
    end

    // Reset mid-period with a pending shadow restores the defaults
    ch_en = 4'b1001;
    cfg_write(2'd0, 8'd9, 1'b0, "cfg_ch0_div9_ready");
    check("pre_rst_pending", pending, 4'b0001);
    check("pre_rst_clk_out", clk_out, 4'b1000);
    cfg_ch = 2'd0;
    rst_n  = 1'b0;
    #1;
    check("arst_clk_out", clk_out, 4'b0000);
    check("arst_tick", tick, 4'b0000);
    check("arst_pending", pending, 4'b0000);
    check("arst_cfg_ready", {3'b000, cfg_ready}, 4'b0001);
    step(); step();
    ch_en = 4'b0001;
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      check("post_rst_tick", tick, {3'b000, k == 14});
      check("post_rst_clk_out", clk_out, {3'b000, k == 15});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
